// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery exponentiation path: FSM states and
// the default operand width used by the core and the top level.
package mont_pkg;

    localparam int DEF_WIDTH = 512;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        PRE_W,
        SQR,
        SQR_W,
        MUL,
        MUL_W,
        POST,
        POST_W,
        FIN
    } mont_state_e;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery
// multiplier over a start/done handshake; computes x^e mod M.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int E_WIDTH = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_r,
    input  logic [WIDTH-1:0]   in_r2,
    output logic [WIDTH-1:0]   result,
    output logic               done,
    output logic               busy,
    output logic               mm_start,
    output logic [WIDTH-1:0]   mm_a,
    output logic [WIDTH-1:0]   mm_b,
    output logic [WIDTH-1:0]   mm_m,
    input  logic [WIDTH-1:0]   mm_result,
    input  logic               mm_done
);

    localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

    mont_state_e        state;
    logic [E_WIDTH-1:0] e_q;
    logic [IW-1:0]      idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   xt;
    logic               last;

    assign last = (idx == '0);

    // x and r2 live in mm_a/mm_b from accept until the PRE product completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            e_q      <= '0;
            idx      <= '0;
            a_q      <= '0;
            xt       <= '0;
            result   <= '0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
            mm_start <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            mm_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        e_q      <= in_e;
                        mm_m     <= in_m;
                        a_q      <= in_r;
                        idx      <= IW'(E_WIDTH - 1);
                        mm_a     <= in_x;
                        mm_b     <= in_r2;
                        mm_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= PRE;
                    end
                end
                PRE:  state <= PRE_W;
                SQR:  state <= SQR_W;
                MUL:  state <= MUL_W;
                POST: state <= POST_W;
                PRE_W: begin
                    if (mm_done) begin
                        xt       <= mm_result;
                        mm_a     <= a_q;
                        mm_b     <= a_q;
                        mm_start <= 1'b1;
                        state    <= SQR;
                    end
                end
                SQR_W: begin
                    if (mm_done) begin
                        a_q      <= mm_result;
                        mm_a     <= mm_result;
                        mm_start <= 1'b1;
                        if (e_q[idx]) begin
                            mm_b  <= xt;
                            state <= MUL;
                        end else if (last) begin
                            mm_b  <= WIDTH'(1);
                            state <= POST;
                        end else begin
                            mm_b  <= mm_result;
                            idx   <= idx - IW'(1);
                            state <= SQR;
                        end
                    end
                end
                MUL_W: begin
                    if (mm_done) begin
                        a_q      <= mm_result;
                        mm_a     <= mm_result;
                        mm_start <= 1'b1;
                        if (last) begin
                            mm_b  <= WIDTH'(1);
                            state <= POST;
                        end else begin
                            mm_b  <= mm_result;
                            idx   <= idx - IW'(1);
                            state <= SQR;
                        end
                    end
                end
                POST_W: begin
                    if (mm_done) begin
                        result <= mm_result;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a behavioural Montgomery core
// (M=13, R=256, R^-1 mod 13 = 3) of programmable latency.
module tb_mont_exp_ctrl;

    localparam int W  = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0;
    logic [EW-1:0] in_e = '0;
    logic [W-1:0]  in_m = 8'd13;
    logic [W-1:0]  in_r = 8'd9;
    logic [W-1:0]  in_r2 = 8'd3;
    logic [W-1:0]  result;
    logic          done, busy, mm_start, mm_done;
    logic [W-1:0]  mm_a, mm_b, mm_m, mm_result;

    int            n_vec = 0;
    int            n_err = 0;
    int            lat = 3;
    int            cnt = 0;
    logic          spur_en = 1'b0;
    logic [W-1:0]  prod = '0;
    int            cyc = 0;
    int            tot_mms = 0;
    int            tot_done = 0;
    int            done_cyc = 0;
    int            hold_bad = 0;
    logic          track = 1'b0;
    logic [W-1:0]  sa = '0, sb = '0, sm = '0;

    mont_exp_ctrl #(.WIDTH(W), .E_WIDTH(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    // Core stand-in: mm_done lands lat cycles after the mm_start cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mm_start) begin
            cnt  <= lat;
            prod <= W'((int'(mm_a) * int'(mm_b) * 3) % 13);
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign mm_result = prod;
    assign mm_done   = (cnt == 1) | (spur_en & mm_start);

    always @(negedge clk) begin
        if (mm_start) tot_mms = tot_mms + 1;
        if (done) begin
            tot_done = tot_done + 1;
            done_cyc = cyc;
        end
        if (!resetn) begin
            track = 1'b0;
        end else if (mm_start) begin
            sa = mm_a; sb = mm_b; sm = mm_m;
            track = 1'b1;
        end else if (track) begin
            if (mm_a !== sa || mm_b !== sb || mm_m !== sm) hold_bad = hold_bad + 1;
            if (mm_done) track = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input logic [W-1:0] x, input logic [EW-1:0] e,
                       input logic [W-1:0] exp_res, input int exp_ops,
                       input int exp_cyc, input bit noise, input string tag);
        int m0, d0, h0, c0;
        bit got;
        m0 = tot_mms; d0 = tot_done; h0 = hold_bad;
        spur_en = noise;
        @(posedge clk); #1;
        in_x = x; in_e = e; start = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (noise && k == 20) begin
                start = 1'b1; in_x = 8'd7; in_e = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        #1;
        spur_en = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_mm_starts"}, 32'(tot_mms - m0), 32'(exp_ops));
        chk({tag, "_done_once"}, 32'(tot_done - d0), 32'd1);
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(hold_bad - h0), 32'd0);
        if (exp_cyc > 0) chk({tag, "_cycles"}, 32'(done_cyc - c0 + 1), 32'(exp_cyc));
    endtask

    initial begin
        int m0, d0;
        bit got;
        #12;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mm_start", 32'(mm_start), 32'd0);
        chk("rst_mm_ops", 32'({mm_a, mm_b, mm_m}), 32'd0);
        #3 resetn = 1'b1;

        // 2^5 mod 13 = 6; 12 products, 12*4+2 cycles
        run(8'd2, 8'd5, 8'd6, 12, 50, 1'b0, "t1");
        d0 = tot_done;
        repeat (4) @(negedge clk);
        #1;
        chk("t1_no_extra_done", 32'(tot_done - d0), 32'd0);
        chk("t1_result_held", 32'(result), 32'd6);

        run(8'd2, 8'd0, 8'd1, 10, 0, 1'b0, "t2");
        run(8'd2, 8'hFF, 8'd8, 18, 74, 1'b0, "t3_l3");
        lat = 1;
        run(8'd2, 8'hFF, 8'd8, 18, 38, 1'b0, "t3_l1");
        lat = 3;

        // back-to-back with stray start and mm_done in issue cycles
        run(8'd0, 8'd7, 8'd0, 2 + 8 + 3, 0, 1'b1, "t4a");
        run(8'd5, 8'd2, 8'd12, 2 + 8 + 1, 0, 1'b1, "t4b");

        // reset in the second SQR_W of 2^5
        m0 = tot_mms;
        @(posedge clk); #1;
        in_x = 8'd2; in_e = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk); #1;
            if (tot_mms - m0 >= 3) got = 1'b1;
        end
        chk("t5_reach_sqr", 32'(got), 32'd1);
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_mm_start", 32'(mm_start), 32'd0);
        chk("t5_rst_result", 32'(result), 32'd0);
        @(negedge clk); #2;
        resetn = 1'b1;
        m0 = tot_mms; d0 = tot_done;
        repeat (5) @(negedge clk);
        #1;
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_stale_ignored", 32'(tot_mms - m0), 32'd0);
        chk("t5_no_done", 32'(tot_done - d0), 32'd0);
        run(8'd2, 8'd5, 8'd6, 12, 50, 1'b0, "t5_rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
Initiator-side controller for the Montgomery multiplier's start/done interface. Computes result = x^e mod M by left-to-right square-and-multiply, issuing one Montgomery product MM(a,b) = a*b*R^-1 mod M at a time (R = 2^WIDTH). Sits between the top-level command registers and a single montgomery core instance, which is a peer at top level and is not instantiated inside this block.

Parameters:
WIDTH, 512, operand/modulus width in bits; R = 2^WIDTH
E_WIDTH, 16, exponent width in bits; every exponent bit is processed, MSB first

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle command pulse; accepted only when busy=0
in_x  in  WIDTH  base, normal domain, < M
in_e  in  E_WIDTH  exponent
in_m  in  WIDTH  odd modulus
in_r  in  WIDTH  R mod M (Montgomery one)
in_r2  in  WIDTH  R^2 mod M
result  out  WIDTH  x^e mod M; held until the next accepted start
done  out  1  one-cycle pulse when result is valid
busy  out  1  high from the cycle after start is accepted until the cycle done pulses
mm_start  out  1  one-cycle pulse to the core
mm_a  out  WIDTH  core operand a, registered
mm_b  out  WIDTH  core operand b, registered
mm_m  out  WIDTH  core modulus, registered copy of in_m
mm_result  in  WIDTH  core product, fully reduced (< M)
mm_done  in  1  core completion pulse

Behaviour:
- Reset (asynchronous, any state): state=IDLE; result, mm_a, mm_b, mm_m, and all internal registers cleared to 0; done=0, busy=0, mm_start=0. Any in-flight operation is abandoned; a stale mm_done after reset is ignored while in IDLE.
- IDLE: when start=1, latch x, e, m, r, r2; load A <= r; load bit index i <= E_WIDTH-1; go to PRE. A start pulse in any other state is ignored and latched operands are unchanged.
- Each product is an ISSUE/WAIT pair:
  - ISSUE state: mm_a and mm_b are already registered; mm_start=1 for exactly that one cycle.
  - WAIT state: mm_a, mm_b, and mm_m are held stable.
  - On the cycle mm_done=1 in WAIT, capture mm_result and move to the next ISSUE state.
  - mm_done in any non-WAIT state is ignored.
- Operation sequence:
  - PRE/PRE_W: MM(x, r2) -> xt (base in Montgomery form).
  - SQR/SQR_W: MM(A, A) -> A. Then, if e[i]=1 go to MUL; otherwise go to NEXT.
  - MUL/MUL_W: MM(A, xt) -> A, then go to NEXT.
  - NEXT (combinational step inside the transition, no extra cycle): if i=0 go to POST; else i <= i-1 and go to SQR.
  - POST/POST_W: MM(A, 1) -> result, then go to FIN.
  - FIN: done=1 for one cycle, busy=0 in that cycle; go to IDLE.
- Latency: with core latency L (cycles from mm_start to mm_done inclusive of the done cycle), N_ops = 2 + E_WIDTH + popcount(e), and total = N_ops*(1+L) + 2 cycles from start to done (the 2 covers the IDLE accept cycle and FIN).
- Edge cases:
  - e=0 -> result = 1 mod M.
  - x=0 with e>0 -> result 0.
  - Index i wraps never: the counter stops at 0.
- A new start is accepted in the cycle after done (IDLE); back-to-back commands need no gap beyond that.

Decomposition:
- Shared package mont_pkg: state enum (IDLE, PRE, PRE_W, SQR, SQR_W, MUL, MUL_W, POST, POST_W, FIN) and default WIDTH=512 constant, reused by the core and the top level.
- No sub-module: the exponent index counter and operand muxes are small enough to stay inline.
- Verification uses a behavioural MM model with configurable L as the core stand-in.

Test Plan:
All scenarios use WIDTH=8, E_WIDTH=8, M=13, r=9, r2=3, and the model with L=3 unless stated.
1. x=2, e=5 -> result=6, done pulses exactly once, exactly 12 mm_start pulses, start-to-done = 12*4+2 = 50 cycles.
2. x=2, e=0 -> result=1 after 10 mm_start pulses.
3. x=2, e=0xFF -> result=8 after 18 mm_start pulses; re-run with L=1 gives the same result in 18*2+2 = 38 cycles.
4. x=0, e=7 -> result=0. Then start x=5, e=2 on the cycle after done -> result=12. Extra start pulses and spurious mm_done in ISSUE states during the run -> ignored, results unchanged.
5. resetn low during SQR_W of an x=2, e=5 run -> immediately done=0, busy=0, mm_start=0, result=0. A late mm_done after release is ignored; a fresh x=2, e=5 run then gives 6.
6. mm_a, mm_b, and mm_m are checked constant every cycle from mm_start until mm_done, for all runs above.
